// File: rtl/e203_exu_brslv_pipe.sv
// ---------------------------------------------------------------------------
// e203_exu_brslv_pipe
//
// Purpose:
//   Branch / flow-change resolution stage at the commit point. It receives
//   one committing instruction per cycle and decides whether the front end
//   must be flushed: a mispredicted branch/jump, fence.i, mret or dret. The
//   flush target and flush type are captured when the instruction is
//   accepted. The request is then held in a FLUSH state until the front end
//   acknowledges it, or until a higher-priority exception/interrupt flush
//   cancels it.
//
// Optional feature:
//   E203_BRSLV_PERFCNT_EN - when defined, builds two saturating counters:
//   accepted branches/jumps and accepted mispredicted branches/jumps.
//   When undefined, both counters read 0 and cnt_clr is ignored.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmt_i_valid / cmt_i_ready     commit handshake
//   cmt_i_rv32                    1: 32-bit instruction, 0: 16-bit
//   cmt_i_dret/mret/fencei/bjp    instruction class
//   cmt_i_bjp_prdt / _rslv        predicted taken / resolved taken
//   cmt_i_pc, cmt_i_imm           instruction PC and branch offset
//   csr_epc_r, csr_dpc_r          return targets for mret / dret
//   nonalu_excpirq_flush_req_raw  higher-priority flush from exceptions/irqs
//   brchmis_flush_req/_ack/_pc    flush request handshake and target
//   cmt_mret/dret/fencei_ena      one-cycle pulse when that flush completes
//   cnt_clr, cnt_bjp, cnt_mispred performance counters
// ---------------------------------------------------------------------------
module e203_exu_brslv_pipe #(
    parameter int PC_W  = 32,
    parameter int IMM_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             cmt_i_valid,
    output logic             cmt_i_ready,
    input  logic             cmt_i_rv32,
    input  logic             cmt_i_dret,
    input  logic             cmt_i_mret,
    input  logic             cmt_i_fencei,
    input  logic             cmt_i_bjp,
    input  logic             cmt_i_bjp_prdt,
    input  logic             cmt_i_bjp_rslv,
    input  logic [PC_W-1:0]  cmt_i_pc,
    input  logic [IMM_W-1:0] cmt_i_imm,
    input  logic [PC_W-1:0]  csr_epc_r,
    input  logic [PC_W-1:0]  csr_dpc_r,

    input  logic             nonalu_excpirq_flush_req_raw,
    output logic             brchmis_flush_req,
    input  logic             brchmis_flush_ack,
    output logic [PC_W-1:0]  brchmis_flush_pc,

    output logic             cmt_mret_ena,
    output logic             cmt_dret_ena,
    output logic             cmt_fencei_ena,

    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_bjp,
    output logic [CNT_W-1:0] cnt_mispred
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    state_e          state_q;
    logic [PC_W-1:0] pc_q;
    logic            mret_q;
    logic            dret_q;
    logic            fencei_q;

    // -----------------------------------------------------------------------
    // Instruction decode
    // -----------------------------------------------------------------------
    logic bjp_mispred;
    logic need_flush;
    logic is_branch;
    logic accept;

    assign bjp_mispred = cmt_i_bjp & (cmt_i_bjp_prdt ^ cmt_i_bjp_rslv);
    assign need_flush  = bjp_mispred | cmt_i_fencei | cmt_i_mret | cmt_i_dret;
    assign is_branch   = cmt_i_bjp | cmt_i_fencei | cmt_i_mret | cmt_i_dret;

    // A pending exception/irq flush blocks only flow-change instructions; the
    // exception path has to see them first.
    assign cmt_i_ready = (state_q == ST_IDLE) &
                         (~nonalu_excpirq_flush_req_raw | ~is_branch);
    assign accept      = cmt_i_valid & cmt_i_ready;

    // -----------------------------------------------------------------------
    // Flush target selection (all additions wrap modulo 2^PC_W)
    // -----------------------------------------------------------------------
    logic [PC_W-1:0] seq_inc;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] br_pc;
    logic [PC_W-1:0] target_pc;

    assign seq_inc = cmt_i_rv32 ? PC_W'(4) : PC_W'(2);
    assign seq_pc  = cmt_i_pc + seq_inc;
    assign br_pc   = cmt_i_pc + cmt_i_imm[PC_W-1:0];

    // NOTE: every path of a combinational block must assign its outputs, or
    // synthesis infers a latch; the if/else chain ends in a plain else.
    always_comb begin
        if (cmt_i_dret) begin
            target_pc = csr_dpc_r;
        end else if (cmt_i_mret) begin
            target_pc = csr_epc_r;
        end else if (cmt_i_fencei) begin
            target_pc = seq_pc;
        end else if (cmt_i_bjp_prdt) begin
            // Predicted taken but resolved not taken: fall through.
            target_pc = seq_pc;
        end else begin
            // Predicted not taken but resolved taken: jump to the target.
            target_pc = br_pc;
        end
    end

    generate
        if (IMM_W > PC_W) begin : g_imm_hi
            // Offset bits above the PC width cannot affect a wrapped sum.
            logic unused_imm_hi;
            assign unused_imm_hi = |cmt_i_imm[IMM_W-1:PC_W];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Flush FSM
    // -----------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            mret_q   <= 1'b0;
            dret_q   <= 1'b0;
            fencei_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && need_flush) begin
                        // CSR return targets are captured here, so later CSR
                        // writes cannot move a pending flush.
                        state_q  <= ST_FLUSH;
                        pc_q     <= target_pc;
                        mret_q   <= cmt_i_mret;
                        dret_q   <= cmt_i_dret;
                        fencei_q <= cmt_i_fencei;
                    end
                end
                ST_FLUSH: begin
                    // An exception/irq flush supersedes this flush, with or
                    // without an ack in the same cycle.
                    if (nonalu_excpirq_flush_req_raw || brchmis_flush_ack) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Completion pulse: acknowledged, not cancelled, and not being reset.
    logic flush_done;

    assign flush_done = (state_q == ST_FLUSH) & brchmis_flush_ack &
                        ~nonalu_excpirq_flush_req_raw & ~rst;

    assign brchmis_flush_req = (state_q == ST_FLUSH) & ~nonalu_excpirq_flush_req_raw;
    assign brchmis_flush_pc  = pc_q;

    assign cmt_mret_ena   = flush_done & mret_q;
    assign cmt_dret_ena   = flush_done & dret_q;
    assign cmt_fencei_ena = flush_done & fencei_q;

    // -----------------------------------------------------------------------
    // Performance counters
    // -----------------------------------------------------------------------
`ifdef E203_BRSLV_PERFCNT_EN
    logic [CNT_W-1:0] cnt_bjp_q;
    logic [CNT_W-1:0] cnt_bjp_d;
    logic [CNT_W-1:0] cnt_mispred_q;
    logic [CNT_W-1:0] cnt_mispred_d;

    // Clear wins over increment; an increment at all-ones holds the value.
    always_comb begin
        cnt_bjp_d     = cnt_bjp_q;
        cnt_mispred_d = cnt_mispred_q;
        if (cnt_clr) begin
            cnt_bjp_d     = '0;
            cnt_mispred_d = '0;
        end else begin
            if (accept && cmt_i_bjp && !(&cnt_bjp_q)) begin
                cnt_bjp_d = cnt_bjp_q + CNT_W'(1);
            end
            if (accept && bjp_mispred && !(&cnt_mispred_q)) begin
                cnt_mispred_d = cnt_mispred_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_bjp_q     <= '0;
            cnt_mispred_q <= '0;
        end else begin
            cnt_bjp_q     <= cnt_bjp_d;
            cnt_mispred_q <= cnt_mispred_d;
        end
    end

    assign cnt_bjp     = cnt_bjp_q;
    assign cnt_mispred = cnt_mispred_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign cnt_bjp        = '0;
    assign cnt_mispred    = '0;
`endif

endmodule

// File: tb/tb_e203_exu_brslv_pipe.sv
// ---------------------------------------------------------------------------
// tb_e203_exu_brslv_pipe
//
// Directed bench for e203_exu_brslv_pipe with hand-computed expectations.
// Inputs change just after the falling edge and outputs are sampled 1 time
// unit later, well away from the rising edge. Counter expectations follow
// whether E203_BRSLV_PERFCNT_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_e203_exu_brslv_pipe;

    localparam int PC_W  = 32;
    localparam int IMM_W = 32;
    localparam int CNT_W = 2;

`ifdef E203_BRSLV_PERFCNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             cmt_i_valid;
    logic             cmt_i_ready;
    logic             cmt_i_rv32;
    logic             cmt_i_dret;
    logic             cmt_i_mret;
    logic             cmt_i_fencei;
    logic             cmt_i_bjp;
    logic             cmt_i_bjp_prdt;
    logic             cmt_i_bjp_rslv;
    logic [PC_W-1:0]  cmt_i_pc;
    logic [IMM_W-1:0] cmt_i_imm;
    logic [PC_W-1:0]  csr_epc_r;
    logic [PC_W-1:0]  csr_dpc_r;
    logic             nonalu_excpirq_flush_req_raw;
    logic             brchmis_flush_req;
    logic             brchmis_flush_ack;
    logic [PC_W-1:0]  brchmis_flush_pc;
    logic             cmt_mret_ena;
    logic             cmt_dret_ena;
    logic             cmt_fencei_ena;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt_bjp;
    logic [CNT_W-1:0] cnt_mispred;

    int n_checks = 0;
    int n_errors = 0;

    e203_exu_brslv_pipe #(
        .PC_W (PC_W),
        .IMM_W(IMM_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk                         (clk),
        .rst                         (rst),
        .cmt_i_valid                 (cmt_i_valid),
        .cmt_i_ready                 (cmt_i_ready),
        .cmt_i_rv32                  (cmt_i_rv32),
        .cmt_i_dret                  (cmt_i_dret),
        .cmt_i_mret                  (cmt_i_mret),
        .cmt_i_fencei                (cmt_i_fencei),
        .cmt_i_bjp                   (cmt_i_bjp),
        .cmt_i_bjp_prdt              (cmt_i_bjp_prdt),
        .cmt_i_bjp_rslv              (cmt_i_bjp_rslv),
        .cmt_i_pc                    (cmt_i_pc),
        .cmt_i_imm                   (cmt_i_imm),
        .csr_epc_r                   (csr_epc_r),
        .csr_dpc_r                   (csr_dpc_r),
        .nonalu_excpirq_flush_req_raw(nonalu_excpirq_flush_req_raw),
        .brchmis_flush_req           (brchmis_flush_req),
        .brchmis_flush_ack           (brchmis_flush_ack),
        .brchmis_flush_pc            (brchmis_flush_pc),
        .cmt_mret_ena                (cmt_mret_ena),
        .cmt_dret_ena                (cmt_dret_ena),
        .cmt_fencei_ena              (cmt_fencei_ena),
        .cnt_clr                     (cnt_clr),
        .cnt_bjp                     (cnt_bjp),
        .cnt_mispred                 (cnt_mispred)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] cnt_exp(input int v);
        return PERF ? 64'(v) : 64'd0;
    endfunction

    // Presents one instruction right after the next falling edge.
    task automatic drive_instr(input logic bjp, input logic prdt, input logic rslv,
                               input logic mret, input logic dret, input logic fencei,
                               input logic rv32, input logic [31:0] pc, input logic [31:0] imm);
        @(negedge clk);
        cmt_i_valid    = 1'b1;
        cmt_i_bjp      = bjp;
        cmt_i_bjp_prdt = prdt;
        cmt_i_bjp_rslv = rslv;
        cmt_i_mret     = mret;
        cmt_i_dret     = dret;
        cmt_i_fencei   = fencei;
        cmt_i_rv32     = rv32;
        cmt_i_pc       = pc;
        cmt_i_imm      = imm;
    endtask

    task automatic clear_instr();
        cmt_i_valid    = 1'b0;
        cmt_i_bjp      = 1'b0;
        cmt_i_bjp_prdt = 1'b0;
        cmt_i_bjp_rslv = 1'b0;
        cmt_i_mret     = 1'b0;
        cmt_i_dret     = 1'b0;
        cmt_i_fencei   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        clear_instr();
        cmt_i_rv32 = 1'b1;
        cmt_i_pc = '0;
        cmt_i_imm = '0;
        csr_epc_r = '0;
        csr_dpc_r = '0;
        nonalu_excpirq_flush_req_raw = 1'b0;
        brchmis_flush_ack = 1'b0;
        cnt_clr = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_req", brchmis_flush_req, 0);
        check("rst_pc", brchmis_flush_pc, 0);
        check("rst_ena", {cmt_mret_ena, cmt_dret_ena, cmt_fencei_ena}, 0);
        check("rst_ready", cmt_i_ready, 1);
        check("rst_cnt_bjp", cnt_bjp, 0);
        check("rst_cnt_mis", cnt_mispred, 0);

        // Mispredicted not-taken branch: target = 0x1000 + 0x20
        drive_instr(1, 0, 1, 0, 0, 0, 1, 32'h0000_1000, 32'h0000_0020);
        #1;
        check("br_ready", cmt_i_ready, 1);
        check("br_req_same_cycle", brchmis_flush_req, 0);
        @(negedge clk);
        clear_instr();
        #1;
        check("br_req", brchmis_flush_req, 1);
        check("br_pc", brchmis_flush_pc, 32'h0000_1020);
        check("br_ready_flush", cmt_i_ready, 0);
        brchmis_flush_ack = 1'b1;
        #1;
        check("br_ena", {cmt_mret_ena, cmt_dret_ena, cmt_fencei_ena}, 0);
        @(negedge clk);
        brchmis_flush_ack = 1'b0;
        #1;
        check("br_idle_req", brchmis_flush_req, 0);
        check("br_idle_ready", cmt_i_ready, 1);

        // mret with delayed ack; epc changes after acceptance
        csr_epc_r = 32'h8000_0100;
        drive_instr(0, 0, 0, 1, 0, 0, 1, 32'h0000_0400, 32'h0);
        @(negedge clk);
        clear_instr();
        csr_epc_r = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            brchmis_flush_ack = (i == 3);
            #1;
            check($sformatf("mret_pc_%0d", i), brchmis_flush_pc, 32'h8000_0100);
            check($sformatf("mret_req_%0d", i), brchmis_flush_req, 1);
            check($sformatf("mret_ready_%0d", i), cmt_i_ready, 0);
            check($sformatf("mret_ena_%0d", i), cmt_mret_ena, (i == 3));
        end
        @(negedge clk);
        brchmis_flush_ack = 1'b0;
        #1;
        check("mret_ena_after", cmt_mret_ena, 0);
        check("mret_req_after", brchmis_flush_req, 0);

        // fence.i, 16-bit, PC wraps to 0
        drive_instr(0, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFE, 32'h0);
        @(negedge clk);
        clear_instr();
        #1;
        check("fencei_pc", brchmis_flush_pc, 32'h0000_0000);
        check("fencei_req", brchmis_flush_req, 1);
        brchmis_flush_ack = 1'b1;
        #1;
        check("fencei_ena", {cmt_mret_ena, cmt_dret_ena, cmt_fencei_ena}, 3'b001);
        @(negedge clk);
        brchmis_flush_ack = 1'b0;

        // Exception pending in IDLE blocks branches only
        @(negedge clk);
        nonalu_excpirq_flush_req_raw = 1'b1;
        cmt_i_valid = 1'b1;
        cmt_i_bjp = 1'b1;
        #1;
        check("excp_branch_ready", cmt_i_ready, 0);
        cmt_i_bjp = 1'b0;
        #1;
        check("excp_plain_ready", cmt_i_ready, 1);
        @(negedge clk);
        nonalu_excpirq_flush_req_raw = 1'b0;
        clear_instr();

        // dret cancelled by exception with simultaneous ack
        csr_dpc_r = 32'h1234_5678;
        drive_instr(0, 0, 0, 0, 1, 0, 1, 32'h0000_0800, 32'h0);
        @(negedge clk);
        clear_instr();
        #1;
        check("dret_req", brchmis_flush_req, 1);
        check("dret_pc", brchmis_flush_pc, 32'h1234_5678);
        nonalu_excpirq_flush_req_raw = 1'b1;
        brchmis_flush_ack = 1'b1;
        #1;
        check("dret_cancel_req", brchmis_flush_req, 0);
        check("dret_cancel_ena", cmt_dret_ena, 0);
        @(negedge clk);
        nonalu_excpirq_flush_req_raw = 1'b0;
        brchmis_flush_ack = 1'b0;
        #1;
        check("dret_idle_req", brchmis_flush_req, 0);
        check("dret_idle_ready", cmt_i_ready, 1);

        // Predicted taken, resolved not taken: fall through to pc + 4
        drive_instr(1, 1, 0, 0, 0, 0, 1, 32'h0000_2000, 32'h0000_0100);
        @(negedge clk);
        clear_instr();
        #1;
        check("prdt_pc", brchmis_flush_pc, 32'h0000_2004);
        brchmis_flush_ack = 1'b1;
        @(negedge clk);
        brchmis_flush_ack = 1'b0;

        // Correctly predicted branches back to back: no flush, ready stays 1
        drive_instr(1, 1, 1, 0, 0, 0, 1, 32'h0000_3000, 32'h0000_0040);
        #1;
        check("b2b_ready_0", cmt_i_ready, 1);
        drive_instr(1, 0, 0, 0, 0, 0, 1, 32'h0000_3004, 32'h0000_0040);
        #1;
        check("b2b_ready_1", cmt_i_ready, 1);
        @(negedge clk);
        clear_instr();
        #1;
        check("b2b_req", brchmis_flush_req, 0);
        // 4 accepted bjp (saturates at 3), 2 mispredicted
        check("sat_cnt_bjp", cnt_bjp, cnt_exp(3));
        check("sat_cnt_mis", cnt_mispred, cnt_exp(2));

        // Reset during FLUSH, with an ack in the same cycle
        drive_instr(1, 0, 1, 0, 0, 0, 1, 32'h0000_4000, 32'h0000_0010);
        @(negedge clk);
        clear_instr();
        #1;
        check("rflush_req", brchmis_flush_req, 1);
        rst = 1'b1;
        brchmis_flush_ack = 1'b1;
        #1;
        check("rflush_ena", {cmt_mret_ena, cmt_dret_ena, cmt_fencei_ena}, 0);
        @(negedge clk);
        rst = 1'b0;
        brchmis_flush_ack = 1'b0;
        #1;
        check("rflush_req_after", brchmis_flush_req, 0);
        check("rflush_pc_after", brchmis_flush_pc, 0);
        check("rflush_cnt", {cnt_bjp, cnt_mispred}, 0);

        // Five mispredicted branches saturate both counters at 3
        for (int i = 0; i < 5; i++) begin
            drive_instr(1, 0, 1, 0, 0, 0, 1, 32'h0000_0100 * (i + 1), 32'h0000_0004);
            @(negedge clk);
            clear_instr();
            brchmis_flush_ack = 1'b1;
            @(negedge clk);
            brchmis_flush_ack = 1'b0;
        end
        #1;
        check("five_cnt_mis", cnt_mispred, cnt_exp(3));
        check("five_cnt_bjp", cnt_bjp, cnt_exp(3));

        // Clear beats a simultaneous accepted branch
        drive_instr(1, 1, 1, 0, 0, 0, 1, 32'h0000_5000, 32'h0000_0008);
        cnt_clr = 1'b1;
        #1;
        check("clr_ready", cmt_i_ready, 1);
        @(negedge clk);
        clear_instr();
        cnt_clr = 1'b0;
        #1;
        check("clr_cnt_bjp", cnt_bjp, 0);
        check("clr_cnt_mis", cnt_mispred, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/e203_exu_brslv_pipe.md
E203_EXU_BRSLV_PIPE -- requirements
Module: e203_exu_brslv_pipe

Interface
REQ-001 SHALL have parameter PC_W, default 32, meaning PC and flush-target width.
REQ-002 SHALL have parameter IMM_W, default 32, meaning immediate width, with IMM_W >= PC_W.
REQ-003 SHALL have parameter CNT_W, default 16, meaning performance-counter width.
REQ-004 SHALL have ports: clk in 1 clock; rst in 1 synchronous active-high reset.
REQ-005 SHALL have ports: cmt_i_valid in 1; cmt_i_ready out 1; cmt_i_rv32 in 1; cmt_i_dret in 1; cmt_i_mret in 1; cmt_i_fencei in 1; cmt_i_bjp in 1; cmt_i_bjp_prdt in 1, predicted taken; cmt_i_bjp_rslv in 1, resolved taken.
REQ-006 SHALL have ports: cmt_i_pc in PC_W; cmt_i_imm in IMM_W; csr_epc_r in PC_W; csr_dpc_r in PC_W.
REQ-007 SHALL have ports: nonalu_excpirq_flush_req_raw in 1, higher-priority flush; brchmis_flush_req out 1; brchmis_flush_ack in 1; brchmis_flush_pc out PC_W.
REQ-008 SHALL have ports: cmt_mret_ena out 1; cmt_dret_ena out 1; cmt_fencei_ena out 1; cnt_clr in 1; cnt_bjp out CNT_W; cnt_mispred out CNT_W.

Function
REQ-009 SHALL compute need_flush = (bjp & (prdt ^ rslv)) | fencei | mret | dret, and is_branch = bjp | fencei | mret | dret.
REQ-010 SHALL implement a 2-state FSM: IDLE and FLUSH.
REQ-011 In IDLE: cmt_i_ready SHALL equal ~nonalu_excpirq_flush_req_raw | ~is_branch.
REQ-012 In IDLE: an accepted (valid & ready) need_flush instruction SHALL register target PC and type (mret/dret/fencei) and move to FLUSH next cycle.
REQ-013 In FLUSH: cmt_i_ready SHALL be 0, brchmis_flush_req SHALL be 1, and brchmis_flush_pc and type SHALL hold stable until exit.
REQ-014 In FLUSH: brchmis_flush_ack=1 with nonalu_excpirq_flush_req_raw=0 SHALL return to IDLE and pulse, for exactly that cycle, the cmt_*_ena matching the registered type.
REQ-015 In FLUSH: nonalu_excpirq_flush_req_raw=1 SHALL cancel the flush, return to IDLE and pulse no ena, also when ack is simultaneous; brchmis_flush_req SHALL be gated to 0 combinationally in that cycle.
REQ-016 Target priority SHALL be: dret -> csr_dpc_r; mret -> csr_epc_r; fencei -> pc + (rv32 ? 4 : 2); bjp mispredicted with prdt=1 -> pc + (rv32 ? 4 : 2); bjp mispredicted with prdt=0 -> pc + imm[PC_W-1:0].
REQ-017 Additions SHALL wrap modulo 2^PC_W.
REQ-018 csr_epc_r/csr_dpc_r SHALL be sampled at acceptance, not during FLUSH.
REQ-019 Latency SHALL be: flush_req asserted exactly 1 cycle after the accept cycle; minimum 2 cycles from accept to next accept of a flushing instruction.
REQ-020 Non-flushing accepted instructions SHALL not change FSM state; back-to-back acceptance at 1 per cycle SHALL be allowed.

Reset
REQ-021 On rst=1 at a clk edge: FSM SHALL go to IDLE, registered PC/type SHALL clear to 0, and counters SHALL clear to 0.
REQ-022 After reset: brchmis_flush_req=0, brchmis_flush_pc=0, all cmt_*_ena=0.
REQ-023 Reset asserted in FLUSH SHALL drop the request next cycle without an ena pulse.

Configuration
REQ-024 With macro E203_BRSLV_PERFCNT_EN defined: cnt_bjp SHALL increment on each accepted bjp.
REQ-025 With E203_BRSLV_PERFCNT_EN defined: cnt_mispred SHALL increment on each accepted mispredicted bjp.
REQ-026 Both counters SHALL saturate at 2^CNT_W-1, and cnt_clr SHALL clear them synchronously, taking priority over increment.
REQ-027 Without E203_BRSLV_PERFCNT_EN: counters SHALL not be built, cnt_bjp/cnt_mispred SHALL be tied to 0, and cnt_clr SHALL be ignored.

Verification
REQ-028 Bench SHALL cover: bjp prdt=0 rslv=1, pc=0x1000, imm=0x20 -> next cycle flush_req=1, flush_pc=0x1020; ack -> IDLE, no ena pulse.
REQ-029 Bench SHALL cover: mret with epc=0x8000_0100, ack delayed 3 cycles -> flush_pc held 0x8000_0100 for 4 cycles, ready=0, cmt_mret_ena pulses 1 cycle at ack.
REQ-030 Bench SHALL cover: fencei rv32=0, pc=0xFFFF_FFFE -> flush_pc=0x0000_0000 (wrap).
REQ-031 Bench SHALL cover: dret in FLUSH with excp=1 and ack=1 same cycle -> flush_req=0 that cycle, no cmt_dret_ena, FSM IDLE.
REQ-032 Bench SHALL cover: PERFCNT_EN, CNT_W=2, 5 mispredicted bjp -> cnt_mispred=3, cnt_bjp=3; cnt_clr with simultaneous bjp -> 0.
